// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the MIPS datapath: it captures the register file read ports and the decoded fields.
// It also bypasses a same-cycle writeback into the operands, detects load-use hazards, and honours EX stall and flush.
module id_ex_stage #(
   parameter int CTRL_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic              id_uses_rt,
   input  logic [4:0]        id_dst,
   input  logic [31:0]       id_rdata1,
   input  logic [31:0]       id_rdata2,
   input  logic [31:0]       id_imm,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              wb_regwrite,
   input  logic [4:0]        wb_writereg,
   input  logic [31:0]       wb_writedata,
   input  logic              ex_stall,
   input  logic              flush,
   output logic              id_stall,
   output logic              ex_valid,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_dst,
   output logic [31:0]       ex_a,
   output logic [31:0]       ex_b,
   output logic [31:0]       ex_imm,
   output logic              ex_regwrite,
   output logic              ex_memread,
   output logic [CTRL_W-1:0] ex_ctrl
);

   logic [4:0]  id_src [2];
   logic [31:0] id_rdat [2];
   logic [4:0]  ex_src [2];
   logic [31:0] byp_next [2];
   logic [1:0]  refresh;
   logic        lu;

   assign id_src[0]  = id_rs;
   assign id_src[1]  = id_rt;
   assign id_rdat[0] = id_rdata1;
   assign id_rdat[1] = id_rdata2;
   assign ex_src[0]  = ex_rs;
   assign ex_src[1]  = ex_rt;

   // Index 0 is operand A (rs) and index 1 is operand B (rt). Register 0 always reads as zero and is never bypassed.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_opnd
         assign byp_next[gi] = (id_src[gi] == 5'd0) ? 32'd0 :
                               (wb_regwrite && (wb_writereg == id_src[gi])) ? wb_writedata :
                               id_rdat[gi];
         assign refresh[gi]  = ex_valid & wb_regwrite & (wb_writereg != 5'd0) &
                               (wb_writereg == ex_src[gi]);
      end
   endgenerate

   assign lu = ex_valid & ex_memread & (ex_dst != 5'd0) & id_valid &
               ((ex_dst == id_rs) | (id_uses_rt & (ex_dst == id_rt)));

   assign id_stall = ex_stall | lu;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_valid    <= 1'b0;
         ex_rs       <= '0;
         ex_rt       <= '0;
         ex_dst      <= '0;
         ex_a        <= '0;
         ex_b        <= '0;
         ex_imm      <= '0;
         ex_regwrite <= 1'b0;
         ex_memread  <= 1'b0;
         ex_ctrl     <= '0;
      end else if (flush) begin
         ex_valid    <= 1'b0;
         ex_regwrite <= 1'b0;
         ex_memread  <= 1'b0;
      end else if (ex_stall) begin
         // A held instruction keeps absorbing writebacks so its operands do not go stale.
         if (refresh[0]) ex_a <= wb_writedata;
         if (refresh[1]) ex_b <= wb_writedata;
      end else if (lu) begin
         ex_valid    <= 1'b0;
         ex_regwrite <= 1'b0;
         ex_memread  <= 1'b0;
      end else begin
         ex_valid    <= id_valid;
         ex_rs       <= id_rs;
         ex_rt       <= id_rt;
         ex_dst      <= id_dst;
         ex_a        <= byp_next[0];
         ex_b        <= byp_next[1];
         ex_imm      <= id_imm;
         ex_regwrite <= id_regwrite & id_valid;
         ex_memread  <= id_memread & id_valid;
         ex_ctrl     <= id_ctrl;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage. It covers reset, pass-through, WB bypass, load-use bubbles, stall refresh and flush priority.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid, id_uses_rt, id_regwrite, id_memread;
   logic [4:0]  id_rs, id_rt, id_dst;
   logic [31:0] id_rdata1, id_rdata2, id_imm;
   logic [7:0]  id_ctrl;
   logic        wb_regwrite;
   logic [4:0]  wb_writereg;
   logic [31:0] wb_writedata;
   logic        ex_stall, flush;
   logic        id_stall, ex_valid, ex_regwrite, ex_memread;
   logic [4:0]  ex_rs, ex_rt, ex_dst;
   logic [31:0] ex_a, ex_b, ex_imm;
   logic [7:0]  ex_ctrl;

   int n_vec = 0;
   int n_bad = 0;

   id_ex_stage #(.CTRL_W(8)) dut (
      .clk(clk), .reset(reset),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .id_dst(id_dst), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .id_ctrl(id_ctrl),
      .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg), .wb_writedata(wb_writedata),
      .ex_stall(ex_stall), .flush(flush), .id_stall(id_stall),
      .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
      .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_ctrl(ex_ctrl)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, wanted %h", tag, obs, exp);
      end else begin
         $display("pass %s: %h", tag, obs);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urt, input logic [4:0] dst,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic rw, input logic mr);
      id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_dst = dst;
      id_rdata1 = r1; id_rdata2 = r2; id_regwrite = rw; id_memread = mr;
   endtask

   task automatic set_wb(input logic we, input logic [4:0] wr, input logic [31:0] wd);
      wb_regwrite = we; wb_writereg = wr; wb_writedata = wd;
   endtask

   initial begin
      reset = 1'b1;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      id_imm = 0; id_ctrl = 0;
      set_wb(0, 0, 0);
      ex_stall = 0; flush = 0;
      step(); step();
      reset = 1'b0;
      step();

      // Pass-through
      set_id(1, 3, 4, 1, 2, 30, 40, 1, 0);
      id_imm = 32'd7; id_ctrl = 8'hA5;
      step();
      check("pass_a", ex_a, 30);
      check("pass_b", ex_b, 40);
      check("pass_valid", {31'd0, ex_valid}, 1);
      check("pass_rs", {27'd0, ex_rs}, 3);
      check("pass_regwrite", {31'd0, ex_regwrite}, 1);
      check("pass_imm", ex_imm, 7);
      check("pass_ctrl", {24'd0, ex_ctrl}, 32'hA5);

      // Asynchronous reset between edges, with random inputs
      id_valid = 1'($urandom); id_rs = 5'($urandom); id_rt = 5'($urandom);
      id_rdata1 = $urandom; id_rdata2 = $urandom; id_imm = $urandom;
      id_ctrl = 8'($urandom); id_regwrite = 1'b1; id_memread = 1'b1;
      set_wb(1'($urandom), 5'($urandom), $urandom);
      #2 reset = 1'b1;
      #1;
      check("rst_valid", {31'd0, ex_valid}, 0);
      check("rst_a", ex_a, 0);
      check("rst_b", ex_b, 0);
      check("rst_fields", {ex_rs, ex_rt, ex_dst, ex_ctrl, ex_regwrite, ex_memread}, 0);
      check("rst_imm", ex_imm, 0);
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      id_imm = 0; id_ctrl = 0;
      set_wb(0, 0, 0);
      ex_stall = 0; flush = 0;
      #1 reset = 1'b0;
      step();

      // WB bypass
      set_id(1, 5, 6, 1, 2, 50, 60, 1, 0);
      set_wb(1, 5, 32'hDEAD);
      step();
      check("byp_a", ex_a, 32'hDEAD);
      check("byp_b_nohit", ex_b, 60);
      set_id(1, 0, 0, 1, 2, 50, 77, 1, 0);
      set_wb(1, 0, 32'hBEEF);
      step();
      check("byp_zero_a", ex_a, 0);
      check("byp_zero_b", ex_b, 0);
      set_id(0, 1, 2, 1, 3, 11, 22, 1, 1);
      set_wb(0, 0, 0);
      step();
      check("inv_valid", {31'd0, ex_valid}, 0);
      check("inv_regwrite", {31'd0, ex_regwrite}, 0);
      check("inv_memread", {31'd0, ex_memread}, 0);

      // Load-use on rs
      set_id(1, 1, 7, 0, 7, 1, 7, 1, 1);
      step();
      check("lw_memread", {31'd0, ex_memread}, 1);
      set_id(1, 7, 2, 1, 8, 70, 20, 1, 0);
      #1;
      check("lu_stall", {31'd0, id_stall}, 1);
      step();
      check("lu_bubble_valid", {31'd0, ex_valid}, 0);
      check("lu_bubble_rw", {31'd0, ex_regwrite}, 0);
      check("lu_bubble_mr", {31'd0, ex_memread}, 0);
      check("lu_released", {31'd0, id_stall}, 0);
      step();
      check("lu_add_valid", {31'd0, ex_valid}, 1);
      check("lu_add_dst", {27'd0, ex_dst}, 8);
      check("lu_add_a", ex_a, 70);

      // Load-use on rt depends on id_uses_rt
      set_id(1, 1, 7, 0, 7, 1, 7, 1, 1);
      step();
      set_id(1, 3, 7, 1, 9, 33, 77, 1, 0);
      #1;
      check("lu_rt_used", {31'd0, id_stall}, 1);
      id_uses_rt = 1'b0;
      #1;
      check("lu_rt_unused", {31'd0, id_stall}, 0);
      step();
      check("lu_rt_enter", {31'd0, ex_valid}, 1);
      check("lu_rt_rt", {27'd0, ex_rt}, 7);

      // Stall hold with refresh of ex_a
      set_id(1, 9, 10, 1, 11, 32'h90, 32'hA0, 1, 0);
      step();
      check("hold_load_a", ex_a, 32'h90);
      ex_stall = 1'b1;
      set_id(1, 1, 2, 1, 3, 32'h111, 32'h222, 0, 1);
      #1;
      check("hold_stall_c1", {31'd0, id_stall}, 1);
      step();
      check("hold_c1_a", ex_a, 32'h90);
      check("hold_stall_c2", {31'd0, id_stall}, 1);
      set_wb(1, 9, 32'h1234);
      step();
      set_wb(0, 0, 0);
      check("hold_c2_a", ex_a, 32'h1234);
      check("hold_c2_b", ex_b, 32'hA0);
      check("hold_c2_fields", {ex_rs, ex_rt, ex_dst, ex_valid, ex_regwrite, ex_memread}, {5'd9, 5'd10, 5'd11, 3'b110});
      check("hold_stall_c3", {31'd0, id_stall}, 1);
      step();
      check("hold_c3_a", ex_a, 32'h1234);
      check("hold_c3_imm", ex_imm, 0);

      // Flush beats stall and load-use
      ex_stall = 1'b0;
      set_id(1, 1, 2, 1, 12, 1, 2, 1, 1);
      step();
      set_id(1, 12, 3, 1, 13, 5, 6, 1, 0);
      ex_stall = 1'b1; flush = 1'b1;
      #1;
      check("flush_stall_in", {31'd0, id_stall}, 1);
      step();
      check("flush_valid", {31'd0, ex_valid}, 0);
      check("flush_rw", {31'd0, ex_regwrite}, 0);
      check("flush_mr", {31'd0, ex_memread}, 0);
      ex_stall = 1'b0; flush = 1'b0;
      step();
      check("after_flush_valid", {31'd0, ex_valid}, 1);
      check("after_flush_dst", {27'd0, ex_dst}, 13);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
